pooling_row_scheduler: RTL and testbench
========================================

# pooling_row_scheduler

Sequencer and arbiter in front of `pooling_layer_top`. It accepts finished conv-output rows from `TOTAL_FEATURE` requesters, one per feature map. It shares the single pooling datapath between them with round-robin arbitration, and never splits a KERNEL_SIZE-row pooling window across features. It drives `input_valid`, `feature_idx`, `feature_row` and `data_in` of the pooling layer, counts its `output_valid` pulses, and flags frame completion.

## Interface
- INPUT_SIZE, 6, row length and rows per feature map; must be an integer multiple of KERNEL_SIZE
- KERNEL_SIZE, 2, pooling window height/width
- TOTAL_FEATURE, 4, number of feature maps / requesters
- Derived: OUT_ROWS = INPUT_SIZE/KERNEL_SIZE; ROW_WIDTH = logb2(INPUT_SIZE); FEATURE_WIDTH = logb2(TOTAL_FEATURE); logb2 = ceil(log2), minimum 1; DW = global `DATA_WIDTH`
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse, begins a frame; ignored unless IDLE
- req  in  TOTAL_FEATURE  bit f: requester f presents a valid row
- row_data  in  TOTAL_FEATURE*INPUT_SIZE*DW  packed rows; feature f occupies slice [(TOTAL_FEATURE-f)*INPUT_SIZE*DW-1 -: INPUT_SIZE*DW]
- grant  out  TOTAL_FEATURE  one-hot, combinational; row consumed this cycle
- pool_valid  out  1  registered; to pooling `input_valid`
- pool_feature_idx  out  FEATURE_WIDTH  registered feature index
- pool_feature_row  out  ROW_WIDTH  registered row index within feature, 0..INPUT_SIZE-1
- pool_data  out  INPUT_SIZE*DW  registered captured row
- pool_out_valid  in  1  pooling `output_valid`; one pulse per completed window
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse at end of frame

## Operation
- State machine: IDLE, ARB, BURST, DRAIN, DONE.
- IDLE → ARB on start:
  - clear row_cnt[f] for all f (width ROW_WIDTH+1), win_cnt and out_cnt
  - set rr pointer so feature 0 has highest priority
- ARB:
  - eligible[f] = req[f] && row_cnt[f] < INPUT_SIZE
  - pick the first eligible f scanning upward (wrapping) from pointer+1; register lock = f, pointer = f, win_cnt = 0; → BURST
  - if none are eligible, stay in ARB
  - if all row_cnt == INPUT_SIZE, → DRAIN
- BURST:
  - grant[lock] = req[lock]; all other grant bits 0
  - on grant: capture the lock's row_data slice into pool_data; pool_feature_idx = lock; pool_feature_row = row_cnt[lock]; pool_valid = 1 next cycle; row_cnt[lock]++ and win_cnt++
  - req[lock] low: wait with no grant to any feature; the window is never abandoned
  - after the KERNEL_SIZE-th grant → ARB
- DRAIN: wait until out_cnt == TOTAL_FEATURE*OUT_ROWS, then → DONE.
- DONE: frame_done = 1 for one cycle, → IDLE.
- out_cnt counts pool_out_valid in every non-IDLE state. It saturates at TOTAL_FEATURE*OUT_ROWS.
- grant is 0 outside BURST. A feature whose row_cnt == INPUT_SIZE is never granted, even with req high.
- start in a non-IDLE state has no effect.

## Timing
- Reset: grant 0, pool_valid 0, pool_feature_idx 0, pool_feature_row 0, pool_data 0, busy 0, frame_done 0, state IDLE, all counters 0.
- Reset asserted mid-frame: everything returns to reset values immediately. The frame in progress is abandoned; the next start begins at feature 0, row 0.
- Latency:
  - start at cycle 0 → ARB in cycle 1 → BURST in cycle 2 → earliest grant in cycle 2 → pool_valid in cycle 3
  - grant → pool_valid: exactly 1 cycle
- pool_valid is a single-cycle pulse per grant. pool_data, pool_feature_idx and pool_feature_row hold their value until the next grant.
- Minimum window cost: 1 ARB cycle + KERNEL_SIZE BURST cycles. Minimum frame: 1 + TOTAL_FEATURE*OUT_ROWS*(KERNEL_SIZE+1) cycles, plus the drain.
- pool_out_valid and a state transition in the same cycle: the count is still taken.
- frame_done is registered and asserted in the DONE cycle. busy falls the following cycle.

## Test plan
- All four req held high, defaults:
  - grant order f0,f0,f1,f1,f2,f2,f3,f3, repeated 3 times
  - pool_feature_row sequence per feature: 0,1, then 2,3, then 4,5
  - 24 pool_valid pulses; respond with 12 pool_out_valid → exactly one frame_done
- f2 drops req after row 0 for 3 cycles while f3 requests: no grant to any feature and pool_valid low for those 3 cycles; then f2 row 1 is granted, then f3.
- Only req[3] high:
  - f3 granted 6 times, rows 0..5, pool_feature_idx 3
  - continued req[3] yields no grant
  - raising req[0] afterwards yields f0 rows 0..5
- start pulsed again in BURST: no effect on counters or grant order. frame_done is a single cycle; busy falls the cycle after it.
- rst_n low in the middle of f1's window: all outputs 0 at once. After release and start, the first grant is f0 with pool_feature_row 0.
- Only 11 pool_out_valid pulses supplied: stays in DRAIN with busy high and no frame_done. The 12th pulse gives frame_done one cycle later.

Source files
------------

// File: rtl/pooling_row_scheduler.sv
// pooling_row_scheduler: round-robin sequencer feeding whole KERNEL_SIZE-row windows
// from TOTAL_FEATURE row requesters into a single shared pooling datapath.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
module pooling_row_scheduler #(
  parameter int INPUT_SIZE = 6,
  parameter int KERNEL_SIZE = 2,
  parameter int TOTAL_FEATURE = 4,
  parameter int DW = `DATA_WIDTH,
  localparam int ROW_WIDTH = (INPUT_SIZE > 2) ? $clog2(INPUT_SIZE) : 1,
  localparam int FEATURE_WIDTH = (TOTAL_FEATURE > 2) ? $clog2(TOTAL_FEATURE) : 1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  input  logic [TOTAL_FEATURE-1:0]               req,
  input  logic [TOTAL_FEATURE*INPUT_SIZE*DW-1:0] row_data,
  output logic [TOTAL_FEATURE-1:0]               grant,
  output logic                                   pool_valid,
  output logic [FEATURE_WIDTH-1:0]               pool_feature_idx,
  output logic [ROW_WIDTH-1:0]                   pool_feature_row,
  output logic [INPUT_SIZE*DW-1:0]               pool_data,
  input  logic                                   pool_out_valid,
  output logic                                   busy,
  output logic                                   frame_done
);
  localparam int OUT_ROWS = INPUT_SIZE / KERNEL_SIZE;
  localparam int TOTAL_OUT = TOTAL_FEATURE * OUT_ROWS;
  localparam int OW = $clog2(TOTAL_OUT + 1);
  localparam int WW = $clog2(KERNEL_SIZE + 1);
  localparam int RW = INPUT_SIZE * DW;
  localparam logic [ROW_WIDTH:0] ROW_MAX = (ROW_WIDTH + 1)'(INPUT_SIZE);
  localparam logic [ROW_WIDTH:0] ROW_ONE = (ROW_WIDTH + 1)'(1);
  localparam logic [OW-1:0] OUT_MAX = OW'(TOTAL_OUT);
  localparam logic [OW-1:0] OUT_ONE = OW'(1);
  localparam logic [WW-1:0] WIN_LAST = WW'(KERNEL_SIZE - 1);
  localparam logic [WW-1:0] WIN_ONE = WW'(1);
  localparam logic [FEATURE_WIDTH-1:0] F_LAST = FEATURE_WIDTH'(TOTAL_FEATURE - 1);
  localparam logic [FEATURE_WIDTH-1:0] F_ONE = FEATURE_WIDTH'(1);

  typedef enum logic [2:0] {IDLE, ARB, BURST, DRAIN, DONE} state_t;

  state_t state_q, state_d;
  logic [ROW_WIDTH:0] row_cnt_q [TOTAL_FEATURE];
  logic [ROW_WIDTH:0] row_cnt_d [TOTAL_FEATURE];
  logic [WW-1:0] win_cnt_q, win_cnt_d;
  logic [OW-1:0] out_cnt_q, out_cnt_d;
  logic [FEATURE_WIDTH-1:0] ptr_q, ptr_d, lock_q, lock_d;
  logic pool_valid_q, pool_valid_d;
  logic [FEATURE_WIDTH-1:0] pool_idx_q, pool_idx_d;
  logic [ROW_WIDTH-1:0] pool_row_q, pool_row_d;
  logic [RW-1:0] pool_data_q, pool_data_d;
  logic frame_done_q, frame_done_d;
  logic [TOTAL_FEATURE-1:0] eligible;
  logic all_done, found;
  logic [FEATURE_WIDTH-1:0] pick, cand;

  // Rotating scan starting one past the last winner gives round-robin fairness.
  always_comb begin
    eligible = '0;
    all_done = 1'b1;
    found = 1'b0;
    pick = '0;
    cand = (ptr_q == F_LAST) ? '0 : ptr_q + F_ONE;
    for (int f = 0; f < TOTAL_FEATURE; f++) begin
      eligible[f] = req[f] && row_cnt_q[f] < ROW_MAX;
      all_done = all_done && row_cnt_q[f] == ROW_MAX;
    end
    for (int i = 0; i < TOTAL_FEATURE; i++) begin
      if (!found && eligible[cand]) begin
        found = 1'b1;
        pick = cand;
      end
      cand = (cand == F_LAST) ? '0 : cand + F_ONE;
    end
  end

  always_comb begin
    grant = '0;
    grant[lock_q] = state_q == BURST && req[lock_q] && row_cnt_q[lock_q] < ROW_MAX;
  end

  always_comb begin
    state_d = state_q;
    row_cnt_d = row_cnt_q;
    win_cnt_d = win_cnt_q;
    ptr_d = ptr_q;
    lock_d = lock_q;
    pool_valid_d = 1'b0;
    pool_idx_d = pool_idx_q;
    pool_row_d = pool_row_q;
    pool_data_d = pool_data_q;
    out_cnt_d = (state_q != IDLE && pool_out_valid && out_cnt_q != OUT_MAX) ? out_cnt_q + OUT_ONE : out_cnt_q;
    case (state_q)
      IDLE:
        if (start) begin
          state_d = ARB;
          for (int f = 0; f < TOTAL_FEATURE; f++) row_cnt_d[f] = '0;
          win_cnt_d = '0;
          out_cnt_d = '0;
          ptr_d = F_LAST;
        end
      ARB:
        if (all_done) state_d = DRAIN;
        else if (found) begin
          state_d = BURST;
          lock_d = pick;
          ptr_d = pick;
          win_cnt_d = '0;
        end
      BURST:
        if (|grant) begin
          pool_valid_d = 1'b1;
          pool_idx_d = lock_q;
          pool_row_d = row_cnt_q[lock_q][ROW_WIDTH-1:0];
          pool_data_d = row_data[(TOTAL_FEATURE - 1 - int'(lock_q)) * RW +: RW];
          row_cnt_d[lock_q] = row_cnt_q[lock_q] + ROW_ONE;
          win_cnt_d = win_cnt_q + WIN_ONE;
          if (win_cnt_q == WIN_LAST) state_d = ARB;
        end
      // Looking at the incremented count lets the final pulse end the frame a cycle sooner.
      DRAIN: if (out_cnt_d == OUT_MAX) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    frame_done_d = state_d == DONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      for (int f = 0; f < TOTAL_FEATURE; f++) row_cnt_q[f] <= '0;
      win_cnt_q <= '0;
      out_cnt_q <= '0;
      ptr_q <= F_LAST;
      lock_q <= '0;
      pool_valid_q <= 1'b0;
      pool_idx_q <= '0;
      pool_row_q <= '0;
      pool_data_q <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_cnt_q <= row_cnt_d;
      win_cnt_q <= win_cnt_d;
      out_cnt_q <= out_cnt_d;
      ptr_q <= ptr_d;
      lock_q <= lock_d;
      pool_valid_q <= pool_valid_d;
      pool_idx_q <= pool_idx_d;
      pool_row_q <= pool_row_d;
      pool_data_q <= pool_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign pool_valid = pool_valid_q;
  assign pool_feature_idx = pool_idx_q;
  assign pool_feature_row = pool_row_q;
  assign pool_data = pool_data_q;
  assign busy = state_q != IDLE;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_pooling_row_scheduler.sv
// tb_pooling_row_scheduler: directed table-driven bench for the pooling row scheduler.
module tb_pooling_row_scheduler;
  localparam int IS = 6;
  localparam int TF = 4;
  localparam int DW = 8;
  localparam int RW = IS * DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic pool_out_valid = 1'b0;
  logic [TF-1:0] req = '0;
  logic [TF*RW-1:0] row_data;
  logic [TF-1:0] grant;
  logic pool_valid, busy, frame_done;
  logic [1:0] pool_feature_idx;
  logic [2:0] pool_feature_row;
  logic [RW-1:0] pool_data;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic st;
    logic [TF-1:0] rq;
    logic ov;
    logic [TF-1:0] g;
    logic pv;
    int idx;
    int row;
  } vec_t;
  vec_t tbl[37];
  int c, fd_n, pv_n, n_other;
  logic prev_fd;
  int rows_seen[8];
  int idx_seen[8];

  always #5 clk = ~clk;

  pooling_row_scheduler #(.INPUT_SIZE(IS), .KERNEL_SIZE(2), .TOTAL_FEATURE(TF), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .req(req), .row_data(row_data),
    .grant(grant), .pool_valid(pool_valid), .pool_feature_idx(pool_feature_idx),
    .pool_feature_row(pool_feature_row), .pool_data(pool_data),
    .pool_out_valid(pool_out_valid), .busy(busy), .frame_done(frame_done)
  );

  function automatic logic [RW-1:0] exp_data(int f);
    logic [RW-1:0] d;
    d = '0;
    for (int k = 0; k < IS; k++) d[RW-1-k*DW -: DW] = 8'(f * 16 + k);
    return d;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Collects pool_valid beats into rows_seen/idx_seen and counts grants outside the allowed mask.
  task automatic collect(input int n, input logic [TF-1:0] ok_mask);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (pool_valid) begin
        if (pv_n < 8) begin
          rows_seen[pv_n] = int'(pool_feature_row);
          idx_seen[pv_n] = int'(pool_feature_idx);
        end
        pv_n++;
      end
      if ((grant & ~ok_mask) != '0) n_other++;
      tick();
    end
  endtask

  initial begin
    for (int f = 0; f < TF; f++)
      for (int k = 0; k < IS; k++) row_data[(TF-f)*RW-1-k*DW -: DW] = 8'(f * 16 + k);
    for (int e = 0; e < 37; e++) begin
      c = e - 1;
      tbl[e].st = e == 5;
      tbl[e].rq = 4'hF;
      tbl[e].ov = c >= 0 && c % 3 == 2;
      tbl[e].g = (c >= 0 && c % 3 < 2) ? 4'(1 << ((c / 3) % 4)) : 4'b0;
      tbl[e].pv = c >= 1 && (c - 1) % 3 < 2;
      tbl[e].idx = tbl[e].pv ? ((c - 1) / 3) % 4 : 0;
      tbl[e].row = tbl[e].pv ? ((c - 1) / 3 / 4) * 2 + (c - 1) % 3 : 0;
    end

    #12;
    chk("reset grant", grant, 0);
    chk("reset pool_valid", pool_valid, 0);
    chk("reset idx", pool_feature_idx, 0);
    chk("reset row", pool_feature_row, 0);
    chk("reset data", pool_data, 0);
    chk("reset busy", busy, 0);
    chk("reset frame_done", frame_done, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Full frame, all requesters active, with a stray start inside a burst.
    start_frame();
    pv_n = 0;
    for (int e = 0; e < 37; e++) begin
      start = tbl[e].st;
      req = tbl[e].rq;
      pool_out_valid = tbl[e].ov;
      @(negedge clk);
      chk($sformatf("tbl%0d grant", e), grant, tbl[e].g);
      chk($sformatf("tbl%0d pool_valid", e), pool_valid, tbl[e].pv);
      if (pool_valid) pv_n++;
      if (tbl[e].pv) begin
        chk($sformatf("tbl%0d idx", e), pool_feature_idx, tbl[e].idx);
        chk($sformatf("tbl%0d row", e), pool_feature_row, tbl[e].row);
        chk($sformatf("tbl%0d data", e), pool_data, exp_data(tbl[e].idx));
      end
      tick();
    end
    start = 1'b0;
    pool_out_valid = 1'b0;
    chk("frame pool_valid count", pv_n, 24);
    fd_n = 0;
    prev_fd = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (prev_fd) chk("busy after frame_done", busy, 0);
      prev_fd = frame_done;
      if (frame_done) begin
        fd_n++;
        chk("busy during frame_done", busy, 1);
      end
      tick();
    end
    chk("frame_done count", fd_n, 1);

    // f2 stalls mid-window while f3 keeps requesting.
    req = 4'hF;
    start_frame();
    repeat (7) tick();
    @(negedge clk);
    chk("f2 row0 grant", grant, 4'b0100);
    tick();
    req = 4'b1011;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d grant", i), grant, 0);
      if (i > 0) chk($sformatf("stall%0d pool_valid", i), pool_valid, 0);
      tick();
    end
    req = 4'hF;
    @(negedge clk);
    chk("resume f2 grant", grant, 4'b0100);
    chk("resume pool_valid low", pool_valid, 0);
    tick();
    @(negedge clk);
    chk("f2 row1 arb grant", grant, 0);
    chk("f2 row1 pool_valid", pool_valid, 1);
    chk("f2 row1 idx", pool_feature_idx, 2);
    chk("f2 row1 row", pool_feature_row, 1);
    tick();
    @(negedge clk);
    chk("f3 after f2 grant", grant, 4'b1000);
    tick();

    // Reset in the middle of f1's window.
    do_reset();
    req = 4'hF;
    start_frame();
    repeat (4) tick();
    @(negedge clk);
    chk("f1 window grant", grant, 4'b0010);
    tick();
    rst_n = 1'b0;
    #1;
    chk("midreset grant", grant, 0);
    chk("midreset pool_valid", pool_valid, 0);
    chk("midreset idx", pool_feature_idx, 0);
    chk("midreset row", pool_feature_row, 0);
    chk("midreset data", pool_data, 0);
    chk("midreset busy", busy, 0);
    chk("midreset frame_done", frame_done, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    start_frame();
    tick();
    @(negedge clk);
    chk("post-reset first grant", grant, 4'b0001);
    tick();
    @(negedge clk);
    chk("post-reset idx", pool_feature_idx, 0);
    chk("post-reset row", pool_feature_row, 0);
    chk("post-reset pool_valid", pool_valid, 1);
    tick();

    // Single requester f3, then f0 joins after f3 is exhausted.
    do_reset();
    req = 4'b1000;
    start_frame();
    pv_n = 0;
    n_other = 0;
    collect(14, 4'b1000);
    chk("f3 only beats", pv_n, 6);
    chk("f3 only foreign grants", n_other, 0);
    for (int j = 0; j < 6; j++) begin
      chk($sformatf("f3 beat%0d row", j), rows_seen[j], j);
      chk($sformatf("f3 beat%0d idx", j), idx_seen[j], 3);
    end
    pv_n = 0;
    n_other = 0;
    collect(8, 4'b0000);
    chk("f3 exhausted grants", n_other, 0);
    chk("f3 exhausted beats", pv_n, 0);
    req = 4'b1001;
    pv_n = 0;
    n_other = 0;
    collect(16, 4'b0001);
    chk("f0 beats", pv_n, 6);
    chk("f0 phase foreign grants", n_other, 0);
    for (int j = 0; j < 6; j++) begin
      chk($sformatf("f0 beat%0d row", j), rows_seen[j], j);
      chk($sformatf("f0 beat%0d idx", j), idx_seen[j], 0);
    end

    // Drain waits for the last pooling output.
    do_reset();
    req = 4'hF;
    start_frame();
    repeat (40) tick();
    req = '0;
    pool_out_valid = 1'b1;
    repeat (11) tick();
    pool_out_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("drain hold%0d busy,frame_done", i), {busy, frame_done}, 2'b10);
      tick();
    end
    pool_out_valid = 1'b1;
    @(negedge clk);
    chk("12th pulse cycle frame_done", frame_done, 0);
    tick();
    pool_out_valid = 1'b0;
    @(negedge clk);
    chk("drain done frame_done,busy", {frame_done, busy}, 2'b11);
    tick();
    @(negedge clk);
    chk("after drain frame_done,busy", {frame_done, busy}, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
